// File: rtl/lamp_conflict_guard.sv
// Lamp conflict guard: registered pass-through of the 14 lamp drives, with filtered and latched
// conflict/sanity faults that force flashing amber. Optional LAMP_GUARD_LOG_EN adds a fault counter.
module lamp_conflict_guard #(
    parameter int unsigned FILTER_CYC = 4,
    parameter int unsigned BOOT_CYC   = 20_000_000,
    parameter int unsigned FLASH_DIV  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       service_i,
    input  logic       clear_i,
    input  logic [3:0] grn_i,
    input  logic [3:0] ylw_i,
    input  logic [3:0] red_i,
    input  logic       ped_grn_i,
    input  logic       ped_red_i,
    output logic [3:0] grn_o,
    output logic [3:0] ylw_o,
    output logic [3:0] red_o,
    output logic       ped_grn_o,
    output logic       ped_red_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o
`ifdef LAMP_GUARD_LOG_EN
    ,
    output logic [7:0] fault_cnt_o
`endif
);

    localparam int unsigned FW = $clog2(FILTER_CYC + 1);
    localparam int unsigned BW = $clog2(BOOT_CYC + 1);
    localparam int unsigned DW = $clog2(FLASH_DIV + 1);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_GRN   = 2'b01;
    localparam logic [1:0] CODE_PED   = 2'b10;
    localparam logic [1:0] CODE_SANE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [DW-1:0] flash_cnt_q, flash_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    grn_q, grn_d;
    logic [3:0]    ylw_q, ylw_d;
    logic [3:0]    red_q, red_d;
    logic          ped_grn_q, ped_grn_d;
    logic          ped_red_q, ped_red_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
`ifdef LAMP_GUARD_LOG_EN
    logic [7:0]    fault_cnt_q, fault_cnt_d;
`endif

    logic       grn_conflict;
    logic       ped_conflict;
    logic       sanity_err;
    logic [3:0] head_bad;
    logic [1:0] viol_code;
    logic       viol;

    // Violation classification; x & (x-1) is non-zero exactly when more than one green is lit.
    always_comb begin
        grn_conflict = |(grn_i & (grn_i - 4'd1));
        ped_conflict = ped_grn_i & (|grn_i);
        for (int i = 0; i < 4; i++) begin
            head_bad[i] = ~((grn_i[i] ^ ylw_i[i] ^ red_i[i]) & ~(grn_i[i] & ylw_i[i] & red_i[i]));
        end
        sanity_err = ~service_i & ((|head_bad) | (ped_grn_i & ped_red_i));
        if (grn_conflict) begin
            viol_code = CODE_GRN;
        end else if (ped_conflict) begin
            viol_code = CODE_PED;
        end else if (sanity_err) begin
            viol_code = CODE_SANE;
        end else begin
            viol_code = CODE_NONE;
        end
        viol = (viol_code != CODE_NONE);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        flt_cnt_d   = flt_cnt_q;
        boot_cnt_d  = boot_cnt_q;
        flash_cnt_d = flash_cnt_q;
        phase_d     = phase_q;
        fault_d     = fault_q;
        code_d      = code_q;
`ifdef LAMP_GUARD_LOG_EN
        fault_cnt_d = fault_cnt_q;
`endif
        grn_d       = 4'h0;
        ylw_d       = 4'h0;
        red_d       = 4'hF;
        ped_grn_d   = 1'b0;
        ped_red_d   = 1'b1;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BW'(BOOT_CYC - 1)) begin
                    boot_cnt_d = '0;
                    state_d    = ST_PASS;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            ST_PASS: begin
                if (viol) begin
                    if (flt_cnt_q == FW'(FILTER_CYC - 1)) begin
                        state_d     = ST_FAULT;
                        flt_cnt_d   = '0;
                        code_d      = viol_code;
                        fault_d     = 1'b1;
                        flash_cnt_d = '0;
                        phase_d     = 1'b1;
`ifdef LAMP_GUARD_LOG_EN
                        if (fault_cnt_q != 8'hFF) begin
                            fault_cnt_d = fault_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        flt_cnt_d = flt_cnt_q + FW'(1);
                    end
                end else begin
                    flt_cnt_d = '0;
                end
            end
            ST_FAULT: begin
                if (clear_i && !viol) begin
                    state_d   = ST_PASS;
                    fault_d   = 1'b0;
                    flt_cnt_d = '0;
                end else if (flash_cnt_q == DW'(FLASH_DIV - 1)) begin
                    flash_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    flash_cnt_d = flash_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Lamps follow the state being entered so fault flashing starts on the entry edge.
        if (state_q == ST_BOOT) begin
            grn_d = 4'h0;
        end else if (state_d == ST_FAULT) begin
            red_d     = 4'h0;
            ped_red_d = 1'b0;
            ylw_d     = {4{phase_d}};
        end else begin
            grn_d     = grn_i;
            ylw_d     = ylw_i;
            red_d     = red_i;
            ped_grn_d = ped_grn_i;
            ped_red_d = ped_red_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            flt_cnt_q   <= '0;
            boot_cnt_q  <= '0;
            flash_cnt_q <= '0;
            phase_q     <= 1'b0;
            grn_q       <= 4'h0;
            ylw_q       <= 4'h0;
            red_q       <= 4'hF;
            ped_grn_q   <= 1'b0;
            ped_red_q   <= 1'b1;
            fault_q     <= 1'b0;
            code_q      <= CODE_NONE;
`ifdef LAMP_GUARD_LOG_EN
            fault_cnt_q <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            flt_cnt_q   <= flt_cnt_d;
            boot_cnt_q  <= boot_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
            grn_q       <= grn_d;
            ylw_q       <= ylw_d;
            red_q       <= red_d;
            ped_grn_q   <= ped_grn_d;
            ped_red_q   <= ped_red_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
`ifdef LAMP_GUARD_LOG_EN
            fault_cnt_q <= fault_cnt_d;
`endif
        end
    end

    assign grn_o        = grn_q;
    assign ylw_o        = ylw_q;
    assign red_o        = red_q;
    assign ped_grn_o    = ped_grn_q;
    assign ped_red_o    = ped_red_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
`ifdef LAMP_GUARD_LOG_EN
    assign fault_cnt_o  = fault_cnt_q;
`endif

endmodule

// File: tb/tb_lamp_conflict_guard.sv
// Bench for lamp_conflict_guard: classification table, hand-written timing sequences and
// randomized traffic checked against a cycle-count reference model.
module tb_lamp_conflict_guard;

    localparam int unsigned FC = 4;
    localparam int unsigned BC = 8;
    localparam int unsigned FD = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       service_i, clear_i;
    logic [3:0] grn_i, ylw_i, red_i;
    logic       ped_grn_i, ped_red_i;
    logic [3:0] grn_o, ylw_o, red_o;
    logic       ped_grn_o, ped_red_o;
    logic       fault_o;
    logic [1:0] fault_code_o;
`ifdef LAMP_GUARD_LOG_EN
    logic [7:0] fault_cnt_o;
`endif

    lamp_conflict_guard #(.FILTER_CYC(FC), .BOOT_CYC(BC), .FLASH_DIV(FD)) dut (
        .clk(clk), .rst(rst), .service_i(service_i), .clear_i(clear_i),
        .grn_i(grn_i), .ylw_i(ylw_i), .red_i(red_i),
        .ped_grn_i(ped_grn_i), .ped_red_i(ped_red_i),
        .grn_o(grn_o), .ylw_o(ylw_o), .red_o(red_o),
        .ped_grn_o(ped_grn_o), .ped_red_o(ped_red_o),
        .fault_o(fault_o), .fault_code_o(fault_code_o)
`ifdef LAMP_GUARD_LOG_EN
        , .fault_cnt_o(fault_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 boot, 1 pass, 2 fault; timing kept as plain cycle ages.
    int          m_mode, m_boot, m_run, m_age, m_fcnt;
    logic [1:0]  m_code;
    logic [13:0] e_lamps;
    logic        e_fault;

    localparam logic [13:0] RESET_LAMPS = {4'h0, 4'h0, 4'hF, 1'b0, 1'b1};

    typedef struct {
        logic [3:0] g, y, r;
        logic       pg, pr, svc;
        logic [1:0] code;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_code();
        int bad = 0;
        if ($countones(grn_i) > 1) return 2'b01;
        if (ped_grn_i && grn_i != 4'h0) return 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (32'(grn_i[i]) + 32'(ylw_i[i]) + 32'(red_i[i]) != 1) bad++;
        end
        if (!service_i && (bad > 0 || (ped_grn_i && ped_red_i))) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_boot = 0; m_run = 0; m_age = 0; m_fcnt = 0;
        m_code = 2'b00; e_lamps = RESET_LAMPS; e_fault = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0]  c;
        logic [13:0] ins;
        c   = ref_code();
        ins = {grn_i, ylw_i, red_i, ped_grn_i, ped_red_i};
        case (m_mode)
            0: begin
                m_boot++;
                if (m_boot == int'(BC)) m_mode = 1;
                e_lamps = RESET_LAMPS;
            end
            1: begin
                m_run = (c != 2'b00) ? m_run + 1 : 0;
                if (m_run == int'(FC)) begin
                    m_mode = 2; m_run = 0; m_age = 0; m_code = c;
                    if (m_fcnt < 255) m_fcnt++;
                    e_lamps = {4'h0, 4'hF, 4'h0, 2'b00};
                end else begin
                    e_lamps = ins;
                end
            end
            default: begin
                if (clear_i && c == 2'b00) begin
                    m_mode = 1; m_run = 0; e_lamps = ins;
                end else begin
                    m_age++;
                    e_lamps = {4'h0, (((m_age / int'(FD)) % 2) == 0) ? 4'hF : 4'h0, 4'h0, 2'b00};
                end
            end
        endcase
        e_fault = (m_mode == 2);
    endtask

    task automatic compare_all();
        check("lamps", {grn_o, ylw_o, red_o, ped_grn_o, ped_red_o}, e_lamps);
        check("fault_o", fault_o, e_fault);
        check("fault_code_o", fault_code_o, m_code);
`ifdef LAMP_GUARD_LOG_EN
        check("fault_cnt_o", fault_cnt_o, m_fcnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic [3:0] g, input logic [3:0] y, input logic [3:0] r,
                          input logic pg, input logic pr);
        grn_i = g; ylw_i = y; red_i = r; ped_grn_i = pg; ped_red_i = pr;
    endtask

    task automatic set_clean();
        set_in(4'h0, 4'h0, 4'hF, 1'b0, 1'b1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset_red", red_o, 4'hF);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_inputs();
        logic [2:0] h;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: h = 3'b100;
                3, 4, 5: h = 3'b010;
                6, 7, 8: h = 3'b001;
                default: h = 3'($urandom_range(0, 7));
            endcase
            grn_i[i] = h[2]; ylw_i[i] = h[1]; red_i[i] = h[0];
        end
        ped_grn_i = ($urandom_range(0, 3) == 0);
        ped_red_i = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1)) : ~ped_grn_i;
        service_i = ($urandom_range(0, 9) == 0);
        clear_i   = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        tbl[0]  = '{4'b0011, 4'b0000, 4'b1100, 1'b0, 1'b1, 1'b0, 2'b01};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0, 2'b10};
        tbl[2]  = '{4'b0011, 4'b0000, 4'b1100, 1'b1, 1'b0, 1'b0, 2'b01};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b11};
        tbl[5]  = '{4'b0001, 4'b0000, 4'b1110, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[6]  = '{4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0, 2'b11};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 2'b11};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[9]  = '{4'b0100, 4'b0000, 4'b1011, 1'b1, 1'b1, 1'b1, 2'b10};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 2'b00};
        tbl[11] = '{4'b1000, 4'b0100, 4'b0011, 1'b0, 1'b1, 1'b0, 2'b00};

        service_i = 1'b0; clear_i = 1'b0;
        set_in(4'b0011, 4'b0000, 4'b1100, 1'b0, 1'b1);
        apply_reset();

        // Boot hold ignores the conflicting greens; clean lamps appear one cycle after boot.
        for (int k = 0; k < int'(BC); k++) begin
            cycle();
            check("boot_red", red_o, 4'hF);
            check("boot_grn", grn_o, 4'h0);
        end
        set_in(4'b0001, 4'b0000, 4'b1110, 1'b0, 1'b1);
        cycle();
        check("first_pass_grn", grn_o, 4'b0001);

        // Classification table: each vector held FC cycles, then cleared.
        for (int t = 0; t < 12; t++) begin
            service_i = tbl[t].svc;
            set_in(tbl[t].g, tbl[t].y, tbl[t].r, tbl[t].pg, tbl[t].pr);
            for (int k = 0; k < int'(FC); k++) cycle();
            check($sformatf("tbl%0d_fault", t), fault_o, (tbl[t].code != 2'b00));
            if (tbl[t].code != 2'b00) check($sformatf("tbl%0d_code", t), fault_code_o, tbl[t].code);
            service_i = 1'b0;
            set_clean();
            clear_i = 1'b1;
            cycle();
            check($sformatf("tbl%0d_cleared", t), fault_o, 1'b0);
            clear_i = 1'b0;
        end

        // Three violating cycles are filtered out.
        set_in(4'b0011, 4'b0000, 4'b1100, 1'b0, 1'b1);
        for (int k = 0; k < int'(FC) - 1; k++) cycle();
        set_clean();
        cycle();
        check("filter_short", fault_o, 1'b0);

        // Four violating cycles: fault, then amber flashes 3 on / 3 off.
        set_in(4'b0011, 4'b0000, 4'b1100, 1'b0, 1'b1);
        for (int k = 0; k < int'(FC); k++) cycle();
        check("fault_entry", fault_o, 1'b1);
        check("fault_entry_code", fault_code_o, 2'b01);
        check("flash_0", ylw_o, 4'hF);
        for (int k = 1; k < 12; k++) begin
            cycle();
            check($sformatf("flash_%0d", k), ylw_o, ((k / 3) % 2 == 0) ? 4'hF : 4'h0);
        end
        clear_i = 1'b1;
        cycle();
        check("clear_with_viol", fault_o, 1'b1);
        set_clean();
        cycle();
        check("clear_clean", fault_o, 1'b0);
        check("code_held", fault_code_o, 2'b01);
        clear_i = 1'b0;

        // Service mode masks the all-dark sanity fault.
        service_i = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cycle();
        check("service_masked", fault_o, 1'b0);
        service_i = 1'b0;
        for (int k = 0; k < int'(FC) - 1; k++) cycle();
        check("sanity_pending", fault_o, 1'b0);
        cycle();
        check("sanity_fault", fault_o, 1'b1);
        check("sanity_code", fault_code_o, 2'b11);

        // Asynchronous reset in the middle of a fault.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_mid_fault_red", red_o, 4'hF);
        check("rst_mid_fault_code", fault_code_o, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        set_clean();
        for (int k = 0; k < int'(BC) + 2; k++) cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            random_inputs();
            cycle();
        end
        service_i = 1'b0; clear_i = 1'b0;

`ifdef LAMP_GUARD_LOG_EN
        set_clean();
        apply_reset();
        for (int k = 0; k < int'(BC) + 1; k++) cycle();
        for (int n = 0; n < 257; n++) begin
            set_in(4'b0011, 4'b0000, 4'b1100, 1'b0, 1'b1);
            for (int k = 0; k < int'(FC); k++) cycle();
            set_clean();
            clear_i = 1'b1;
            cycle();
            clear_i = 1'b0;
        end
        check("log_saturated", fault_cnt_o, 8'd255);
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        check("log_kept_on_clear", fault_cnt_o, 8'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
